// File: rtl/lcd_pkg.sv
// Shared definitions for the SPI LCD frame sequencer: state codes, panel
// command opcodes and the init ROM entry layout.
package lcd_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_RST_LO   = 4'd1;
  localparam state_t ST_RST_HI   = 4'd2;
  localparam state_t ST_INIT     = 4'd3;
  localparam state_t ST_WAKE     = 4'd4;
  localparam state_t ST_WIN      = 4'd5;
  localparam state_t ST_PX_FETCH = 4'd6;
  localparam state_t ST_PX_HI    = 4'd7;
  localparam state_t ST_PX_LO    = 4'd8;
  localparam state_t ST_DONE     = 4'd9;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_MADCTL = 8'h36;
  localparam logic [7:0] CMD_COLMOD = 8'h3A;
  localparam logic [7:0] CMD_INVON  = 8'h21;
  localparam logic [7:0] CMD_DISPON = 8'h29;

  // Index of the RAMWR byte, the last of the window setup sequence.
  localparam logic [3:0] WIN_LAST_IDX = 4'd10;

  // One init ROM entry; is_end marks the terminator and is never sent.
  typedef struct packed {
    logic       is_end;
    logic       delay;
    logic       dc;
    logic [7:0] data;
  } rom_entry_t;

endpackage

// File: rtl/lcd_init_rom.sv
// ST7735 init command list as a combinational ROM. Each entry is one byte;
// SLPOUT carries the delay flag so the panel gets its wake-up pause.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [10:0] entry
);

  rom_entry_t e;

  assign entry = e;

  // Table lookup; any address past the list reads as the terminator.
  always_comb begin
    e = '{is_end: 1'b1, delay: 1'b0, dc: 1'b0, data: 8'h00};
    case (addr)
      6'd0: e = '{is_end: 1'b0, delay: 1'b1, dc: 1'b0, data: CMD_SLPOUT};
      6'd1: e = '{is_end: 1'b0, delay: 1'b0, dc: 1'b0, data: CMD_MADCTL};
      6'd2: e = '{is_end: 1'b0, delay: 1'b0, dc: 1'b1, data: 8'h68};
      6'd3: e = '{is_end: 1'b0, delay: 1'b0, dc: 1'b0, data: CMD_COLMOD};
      6'd4: e = '{is_end: 1'b0, delay: 1'b0, dc: 1'b1, data: 8'h05};
      6'd5: e = '{is_end: 1'b0, delay: 1'b0, dc: 1'b0, data: CMD_INVON};
      6'd6: e = '{is_end: 1'b0, delay: 1'b0, dc: 1'b0, data: CMD_DISPON};
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Frame sequencer for a 160x80 SPI LCD: panel reset pulse, init ROM stream,
// window setup and a raster RGB565 pixel stream over a valid/ready byte port.
// Optional build macro LCD_SEQ_AUTOREFRESH_EN: once started, frames repeat
// back to back and busy never drops.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int H_RES       = 160,
  parameter int V_RES       = 80,
  parameter int COL_OFS     = 26,
  parameter int ROW_OFS     = 1,
  parameter int RST_CYCLES  = 100000,
  parameter int WAKE_CYCLES = 1200000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        lcd_rstx,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_dc,
  output logic [7:0]  tx_data,
  output logic        px_rd,
  output logic [7:0]  px_x,
  output logic [6:0]  px_y,
  input  logic [15:0] px_data,
  output logic [15:0] H_pos,
  output logic [15:0] V_pos
);

`ifdef LCD_SEQ_AUTOREFRESH_EN
  localparam bit AUTO_REFRESH = 1'b1;
`else
  localparam bit AUTO_REFRESH = 1'b0;
`endif

  localparam int CNT_MAX = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [15:0] H_LAST  = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST  = 16'(V_RES - 1);
  localparam logic [7:0]  COL_BEG = 8'(COL_OFS);
  localparam logic [7:0]  COL_END = 8'(COL_OFS + H_RES - 1);
  localparam logic [7:0]  ROW_BEG = 8'(ROW_OFS);
  localparam logic [7:0]  ROW_END = 8'(ROW_OFS + V_RES - 1);

  state_t           state;
  logic             init_done;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       rom_ptr;
  logic             cur_delay;
  logic [3:0]       win_idx;
  logic [7:0]       px_lo;
  logic [10:0]      rom_bits;
  rom_entry_t       rom_e;
  logic [8:0]       win_next;
  logic             row_end;
  logic             last_px;
  logic [15:0]      h_next;
  logic [15:0]      v_next;

  lcd_init_rom u_rom (
    .addr  (rom_ptr),
    .entry (rom_bits)
  );

  // Window setup byte {dc, data} for each position of the CASET/RASET/RAMWR run.
  function automatic logic [8:0] win_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    win_byte = {1'b0, CMD_CASET};
      4'd1:    win_byte = {1'b1, 8'h00};
      4'd2:    win_byte = {1'b1, COL_BEG};
      4'd3:    win_byte = {1'b1, 8'h00};
      4'd4:    win_byte = {1'b1, COL_END};
      4'd5:    win_byte = {1'b0, CMD_RASET};
      4'd6:    win_byte = {1'b1, 8'h00};
      4'd7:    win_byte = {1'b1, ROW_BEG};
      4'd8:    win_byte = {1'b1, 8'h00};
      4'd9:    win_byte = {1'b1, ROW_END};
      default: win_byte = {1'b0, CMD_RAMWR};
    endcase
  endfunction

  assign rom_e    = rom_entry_t'(rom_bits);
  assign win_next = win_byte(win_idx + 4'd1);
  assign row_end  = (H_pos == H_LAST);
  assign last_px  = row_end && (V_pos == V_LAST);
  assign h_next   = row_end ? 16'd0 : H_pos + 16'd1;
  assign v_next   = row_end ? V_pos + 16'd1 : V_pos;

  // Sequencer FSM; owns every output and the byte handshake. A new byte is
  // only loaded when the port is empty or the current byte is being accepted.
  // Pause counters start at 1 because the INIT reload cycle that follows
  // them still shows tx_valid low and completes the pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      init_done  <= 1'b0;
      cnt        <= '0;
      rom_ptr    <= '0;
      cur_delay  <= 1'b0;
      win_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      lcd_rstx   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_dc      <= 1'b0;
      tx_data    <= '0;
      px_rd      <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      H_pos      <= '0;
      V_pos      <= '0;
    end else begin
      frame_done <= 1'b0;
      px_rd      <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          busy <= 1'b1;
          if (init_done) begin
            state             <= ST_WIN;
            win_idx           <= '0;
            tx_valid          <= 1'b1;
            {tx_dc, tx_data}  <= win_byte(4'd0);
          end else begin
            state    <= ST_RST_LO;
            lcd_rstx <= 1'b0;
            cnt      <= '0;
          end
        end
        ST_RST_LO: begin
          if (cnt == RST_LAST) begin
            state    <= ST_RST_HI;
            lcd_rstx <= 1'b1;
            cnt      <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RST_HI: begin
          if (cnt >= RST_LAST) begin
            state   <= ST_INIT;
            rom_ptr <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_INIT: if (!tx_valid || tx_ready) begin
          if (tx_valid && cur_delay) begin
            tx_valid <= 1'b0;
            state    <= ST_WAKE;
            cnt      <= CNT_W'(1);
          end else if (rom_e.is_end) begin
            init_done        <= 1'b1;
            state            <= ST_WIN;
            win_idx          <= '0;
            tx_valid         <= 1'b1;
            {tx_dc, tx_data} <= win_byte(4'd0);
          end else begin
            tx_valid  <= 1'b1;
            tx_dc     <= rom_e.dc;
            tx_data   <= rom_e.data;
            cur_delay <= rom_e.delay;
            rom_ptr   <= rom_ptr + 6'd1;
          end
        end
        ST_WAKE: begin
          if (cnt >= WAKE_LAST) begin
            state <= ST_INIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WIN: if (tx_ready) begin
          if (win_idx == WIN_LAST_IDX) begin
            tx_valid <= 1'b0;
            state    <= ST_PX_FETCH;
            px_rd    <= 1'b1;
            px_x     <= H_pos[7:0];
            px_y     <= V_pos[6:0];
          end else begin
            win_idx          <= win_idx + 4'd1;
            {tx_dc, tx_data} <= win_next;
          end
        end
        ST_PX_FETCH: state <= ST_PX_HI;
        ST_PX_HI: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_dc    <= 1'b1;
            tx_data  <= px_data[15:8];
          end else if (tx_ready) begin
            state   <= ST_PX_LO;
            tx_data <= px_lo;
          end
        end
        ST_PX_LO: if (tx_ready) begin
          tx_valid <= 1'b0;
          if (last_px) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
            busy       <= AUTO_REFRESH;
          end else begin
            H_pos <= h_next;
            V_pos <= v_next;
            px_rd <= 1'b1;
            px_x  <= h_next[7:0];
            px_y  <= v_next[6:0];
            state <= ST_PX_FETCH;
          end
        end
        ST_DONE: begin
          H_pos <= '0;
          V_pos <= '0;
`ifdef LCD_SEQ_AUTOREFRESH_EN
          state            <= ST_WIN;
          win_idx          <= '0;
          tx_valid         <= 1'b1;
          {tx_dc, tx_data} <= win_byte(4'd0);
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Low pixel byte held from the capture cycle until PX_LO presents it.
  always_ff @(posedge clk) begin
    if (state == ST_PX_HI && !tx_valid) px_lo <= px_data[7:0];
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Self-checking bench for lcd_frame_sequencer with a reduced 4x2 panel.
`timescale 1ns/1ps
module tb_lcd_frame_sequencer;

  localparam int H_RES = 4, V_RES = 2, COL_OFS = 26, ROW_OFS = 1;
  localparam int RST_CYCLES = 5, WAKE_CYCLES = 8;
`ifdef LCD_SEQ_AUTOREFRESH_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tx_ready = 1'b1;
  logic [15:0] px_data = 16'hBAD0;
  logic busy, frame_done, lcd_rstx, tx_valid, tx_dc, px_rd;
  logic [7:0] tx_data, px_x;
  logic [6:0] px_y;
  logic [15:0] H_pos, V_pos;

  int errors = 0, checks = 0;
  bit rnd_ready = 1'b0;
  logic [15:0] px_stage = 16'hBAD0;

  typedef struct packed { logic dc; logic [7:0] data; } byte_t;
  byte_t got[$];
  byte_t exp_q[$];
  byte_t init_tab[7];
  byte_t win_tab[11];
  logic prev_stall = 1'b0;
  byte_t prev_b;

  typedef struct { bit rnd; bit with_init; bit timed; int exp_count; } scen_t;
  scen_t scen[3];

  lcd_frame_sequencer #(
    .H_RES(H_RES), .V_RES(V_RES), .COL_OFS(COL_OFS), .ROW_OFS(ROW_OFS),
    .RST_CYCLES(RST_CYCLES), .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .lcd_rstx(lcd_rstx), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dc(tx_dc),
    .tx_data(tx_data), .px_rd(px_rd), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .H_pos(H_pos), .V_pos(V_pos)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter and pixel source models, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    tx_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    px_data  = px_stage;
    px_stage = px_rd ? {1'b0, px_y, px_x} : 16'hBAD0;
  end

  // Byte log plus handshake, pixel-address and frame_done invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_byte", 32'({tx_dc, tx_data}), 32'(prev_b));
      end
      if (tx_valid && tx_ready) got.push_back({tx_dc, tx_data});
      prev_stall = tx_valid && !tx_ready;
      prev_b     = {tx_dc, tx_data};
      if (px_rd) begin
        check("px_x", 32'(px_x), 32'(H_pos));
        check("px_y", 32'(px_y), 32'(V_pos));
      end
      if (frame_done) check("busy_at_done", 32'(busy), 32'(AR));
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference stream for one frame, derived from the panel geometry.
  task automatic add_frame(input bit with_init);
    if (with_init) foreach (init_tab[i]) exp_q.push_back(init_tab[i]);
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'(COL_OFS)});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'(COL_OFS + H_RES - 1)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'(ROW_OFS)});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'(ROW_OFS + V_RES - 1)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int y = 0; y < V_RES; y++)
      for (int x = 0; x < H_RES; x++) begin
        int p;
        p = y * 256 + x;
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count_min"}, 32'(got.size() >= exp_q.size()), 32'd1);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rstx"}, 32'(lcd_rstx), 32'd0);
    check({tag, "_tx"}, 32'({tx_valid, tx_dc, tx_data}), 32'd0);
    check({tag, "_px"}, 32'({px_rd, px_x, px_y}), 32'd0);
    check({tag, "_busy_done"}, 32'({busy, frame_done}), 32'd0);
    check({tag, "_pos"}, {H_pos, V_pos}, 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input bit with_init, input bit timed, input int exp_count);
    int lo = 0, hi = 0, gap = 0, cyc = 0, base;
    logic prev_busy = 1'b0;
    got.delete();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    if (!with_init) begin
      check("first_valid", 32'(tx_valid), 32'd1);
      check("first_byte", 32'({tx_dc, tx_data}), 32'h02A);
      check("no_rst_pulse", 32'(lcd_rstx), 32'd1);
    end else begin
      while (!lcd_rstx && lo < 50) begin lo++; @(posedge clk); #1; end
      while (lcd_rstx && !tx_valid && hi < 50) begin hi++; @(posedge clk); #1; end
      if (timed) begin
        check("rstx_low_cycles", lo, RST_CYCLES);
        check("rstx_high_cycles", hi, RST_CYCLES);
        @(posedge clk); #1;
        while (!tx_valid && gap < 50) begin gap++; @(posedge clk); #1; end
        check("wake_gap", gap, WAKE_CYCLES);
      end
    end
    while (!frame_done && cyc < 5000) begin
      prev_busy = busy;
      @(posedge clk); #1;
      cyc++;
    end
    check("frame_done_seen", 32'(frame_done), 32'd1);
    if (frame_done) begin
      check("busy_drop", 32'(busy), 32'd0);
      check("busy_before_done", 32'(prev_busy), 32'd1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("done_pulse_width", 32'(frame_done), 32'd0);
      check("start_at_done_ignored", 32'({busy, tx_valid}), 32'd0);
      check("pos_cleared", {H_pos, V_pos}, 32'd0);
    end
    check("byte_count", got.size(), exp_count);
    exp_q.delete();
    add_frame(with_init);
    compare_stream("frame");
    base = with_init ? 7 : 0;
    for (int i = 0; i < 11; i++)
      if (base + i < got.size()) check($sformatf("win_tab%0d", i), 32'(got[base + i]), 32'(win_tab[i]));
  endtask

  initial begin
    int cyc, nfd, busy_low;
    init_tab = '{ {1'b0, 8'h11}, {1'b0, 8'h36}, {1'b1, 8'h68}, {1'b0, 8'h3A},
                  {1'b1, 8'h05}, {1'b0, 8'h21}, {1'b0, 8'h29} };
    win_tab  = '{ {1'b0, 8'h2A}, {1'b1, 8'h00}, {1'b1, 8'h1A}, {1'b1, 8'h00},
                  {1'b1, 8'h1D}, {1'b0, 8'h2B}, {1'b1, 8'h00}, {1'b1, 8'h01},
                  {1'b1, 8'h00}, {1'b1, 8'h02}, {1'b0, 8'h2C} };
    scen[0] = '{rnd: 1'b0, with_init: 1'b1, timed: 1'b1, exp_count: 34};
    scen[1] = '{rnd: 1'b0, with_init: 1'b0, timed: 1'b1, exp_count: 27};
    scen[2] = '{rnd: 1'b1, with_init: 1'b0, timed: 1'b0, exp_count: 27};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_values("por");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 32'({busy, tx_valid, lcd_rstx}), 32'd0);

`ifdef LCD_SEQ_AUTOREFRESH_EN
    got.delete();
    pulse_start();
    check("ar_start_busy", 32'(busy), 32'd1);
    nfd = 0; cyc = 0; busy_low = 0;
    while (nfd < 3 && cyc < 20000) begin
      if (!busy) busy_low++;
      if (frame_done) begin
        nfd++;
        check("ar_pos_at_done", {H_pos, V_pos}, {16'(H_RES - 1), 16'(V_RES - 1)});
        if (nfd == 2) start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (nfd > 0 && H_pos == 16'd0 && V_pos == 16'd0 && tx_valid && tx_data == 8'h2A && !tx_dc)
        check("ar_pos_wrap", 32'(busy), 32'd1);
    end
    check("ar_frames", nfd, 3);
    check("ar_busy_never_low", busy_low, 0);
    exp_q.delete();
    add_frame(1'b1);
    add_frame(1'b0);
    add_frame(1'b0);
    compare_stream("ar");
`else
    for (int s = 0; s < 3; s++) begin
      rnd_ready = scen[s].rnd;
      run_frame(scen[s].with_init, scen[s].timed, scen[s].exp_count);
    end

    // Abort in the middle of the low byte of pixel (2,1).
    rnd_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!(H_pos == 16'd2 && V_pos == 16'd1 && tx_valid && tx_data == 8'h02) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_px_2_1_lo", 32'(cyc < 2000), 32'd1);
    #10 rst = 1'b1;
    #1 check_reset_values("abort");
    @(posedge clk); #1 rst = 1'b0;
    check_reset_values("abort_release");
    run_frame(1'b1, 1'b1, 34);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sequencer.md
# lcd_frame_sequencer

Sequences the byte-level SPI LCD transmitter for the 160x80 panel: power-on reset pulse, init command stream, window setup (CASET/RASET/RAMWR) and a full-frame RGB565 pixel stream. It sits between the pixel source (framebuffer or renderer) and the SPI byte transmitter. It is the sole master of the transmitter's byte handshake and of the panel reset line. It publishes the H_pos/V_pos scan counters that the rest of the graphics path keys off.

## Interface
- H_RES, 160, active columns
- V_RES, 80, active rows
- COL_OFS, 26, panel column offset (8-bit; COL_OFS+H_RES-1 < 256)
- ROW_OFS, 1, panel row offset (8-bit; ROW_OFS+V_RES-1 < 256)
- RST_CYCLES, 100000, LCD_RSTX low time, then the same count high before init (10 ms at 10 MHz)
- WAKE_CYCLES, 1200000, pause after a ROM entry flagged delay (120 ms)

Ports:
- clk  in  1  system clock, 10 MHz
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle frame request; ignored while busy=1
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel byte is accepted
- lcd_rstx  out  1  panel hardware reset, active low
- tx_valid  out  1  byte valid to SPI transmitter
- tx_ready  in  1  transmitter accepts the byte when tx_valid&tx_ready
- tx_dc  out  1  0=command, 1=data
- tx_data  out  8  byte to send
- px_rd  out  1  pixel read strobe
- px_x  out  8  pixel column for px_rd
- px_y  out  7  pixel row for px_rd
- px_data  in  16  RGB565, valid exactly 1 cycle after px_rd
- H_pos  out  16  current column, 0..H_RES-1
- V_pos  out  16  current row, 0..V_RES-1

## Operation
States:
- IDLE
- RST_LO: lcd_rstx=0 for RST_CYCLES
- RST_HI: lcd_rstx=1 for RST_CYCLES
- INIT: stream ROM entries
- WAKE: wait WAKE_CYCLES
- WIN: CASET, 4 bytes, RASET, 4 bytes, RAMWR
- PX_FETCH
- PX_HI
- PX_LO
- DONE

Transitions:
- First start after reset: IDLE->RST_LO->RST_HI->INIT. init_done is set when INIT finishes.
- Later starts go IDLE->WIN directly.
- INIT:
  - ROM entry {end, delay, dc, data}.
  - Each entry is sent as one byte.
  - If delay=1, go to WAKE after acceptance, then resume at the next entry.
  - An entry with end=1 is not sent; go to WIN.
- WIN byte sequence:
  - dc=0 2A
  - dc=1 00, COL_OFS, 00, COL_OFS+H_RES-1
  - dc=0 2B
  - dc=1 00, ROW_OFS, 00, ROW_OFS+V_RES-1
  - dc=0 2C
- Pixel loop:
  - PX_FETCH pulses px_rd with px_x=H_pos, px_y=V_pos.
  - px_data is registered on the next cycle.
  - PX_HI sends data[15:8] (dc=1), then PX_LO sends data[7:0] (dc=1).
  - Then H_pos increments. At H_RES-1 it wraps to 0 and V_pos increments.
  - After (H_RES-1, V_RES-1) is sent, go to DONE.
- DONE: pulse frame_done, clear H_pos/V_pos, go to IDLE (see Configuration).

Handshake rules:
- tx_valid, once raised, stays high with tx_dc/tx_data stable until accepted.
- Never more than one byte outstanding.

## Timing
- Reset values:
  - lcd_rstx=0, tx_valid=0, tx_dc=0, tx_data=0
  - px_rd=0, px_x=0, px_y=0
  - busy=0, frame_done=0, H_pos=0, V_pos=0
  - state IDLE, init_done=0
- Reset at any point, including mid-byte, aborts immediately. The next start re-runs the panel reset and init.
- start→busy: 1 cycle.
- start→tx_valid in WIN (init_done=1): 1 cycle.
- Per pixel with tx_ready held high: 4 cycles (fetch, capture, hi, lo).
- tx_ready high in the same cycle tx_valid rises counts as acceptance. The next byte may be presented on the following cycle.
- start coincident with frame_done: ignored.

## Configuration
- LCD_SEQ_AUTOREFRESH_EN defined:
  - DONE goes straight to WIN; busy stays high.
  - frame_done still pulses every frame.
  - start is ignored after the first start.
- Undefined: DONE→IDLE, busy drops with frame_done, and each frame needs a start.

## Structure
- Package lcd_pkg:
  - state enum
  - opcode constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C
  - ROM entry struct {end, delay, dc, data}
- Sub-module lcd_init_rom:
  - Combinational ROM indexed by a 6-bit pointer.
  - Holds the ST7735 init list: SLPOUT(delay), MADCTL, COLMOD=05, INVON, DISPON, end.

## Test plan
- Test parameters: H_RES=4, V_RES=2, RST_CYCLES=5, WAKE_CYCLES=8, tx_ready tied 1.
- Reset, then start.
  - lcd_rstx low exactly 5 cycles, then high 5 cycles.
  - Then the ROM bytes, with an 8-cycle gap after SLPOUT.
  - Then the window bytes 2A,00,1A,00,1D,2B,00,01,00,02,2C with dc pattern 0,1,1,1,1,0,1,1,1,1,0.
- px_data = {px_y, px_x} pattern.
  - 16 dc=1 bytes in raster order.
  - frame_done pulses once; busy falls the same cycle.
- Second start: no lcd_rstx pulse, first byte 2A one cycle after start.
- tx_ready random 30% duty: byte sequence identical, and tx_data/tx_dc never change while tx_valid&!tx_ready.
- Assert rst during PX_LO of pixel (2,1): all outputs return to reset values asynchronously. The next start repeats the full reset/init.
- With LCD_SEQ_AUTOREFRESH_EN: three back-to-back frames, three frame_done pulses, busy constant 1, H_pos/V_pos wrap 3→0, 1→0.
